// File: rtl/axil_to_cpu_if.sv
// AXI4-Lite slave to cpu_if master bridge, one outstanding access, reads/writes arbitrated alternately.
// Optional `CPU_IF_TIMEOUT_EN aborts a stalled cpu_if access after TIMEOUT_CYCLES wait cycles.
module axil_to_cpu_if #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s_axil_awaddr,
   input  logic        s_axil_awvalid,
   output logic        s_axil_awready,
   input  logic [31:0] s_axil_wdata,
   input  logic [3:0]  s_axil_wstrb,
   input  logic        s_axil_wvalid,
   output logic        s_axil_wready,
   output logic [1:0]  s_axil_bresp,
   output logic        s_axil_bvalid,
   input  logic        s_axil_bready,
   input  logic [31:0] s_axil_araddr,
   input  logic        s_axil_arvalid,
   output logic        s_axil_arready,
   output logic [31:0] s_axil_rdata,
   output logic [1:0]  s_axil_rresp,
   output logic        s_axil_rvalid,
   input  logic        s_axil_rready,
   output logic        cpu_if_read,
   output logic        cpu_if_write,
   output logic [31:0] cpu_if_write_data,
   output logic [29:0] cpu_if_address,
   input  logic [31:0] cpu_if_read_data,
   input  logic        cpu_if_access_complete
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;

   state_t      state, state_nxt;
   logic        last_wr;
   logic        wr_cand, rd_cand, grant_wr, grant_rd, strb_ok, expired, wait_end;
   logic [29:0] addr_q;
   logic [31:0] wdata_q, rdata_q;
   logic [1:0]  bresp_q, rresp_q;

   assign wr_cand  = s_axil_awvalid & s_axil_wvalid;
   assign rd_cand  = s_axil_arvalid;
   // Contention goes to the type not served last, so neither side starves.
   assign grant_wr = (state == IDLE) & wr_cand & (~rd_cand | ~last_wr);
   assign grant_rd = (state == IDLE) & rd_cand & (~wr_cand |  last_wr);
   assign strb_ok  = (s_axil_wstrb == 4'hF);
   assign wait_end = cpu_if_access_complete | expired;

`ifdef CPU_IF_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                      wait_cnt <= '0;
      else if (state == WR_REQ || state == RD_REQ)    wait_cnt <= '0;
      else if (state == WR_WAIT || state == RD_WAIT)  wait_cnt <= wait_cnt + 1'b1;
   end

   assign expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_wr)      state_nxt = strb_ok ? WR_REQ : WR_RESP;
            else if (grant_rd) state_nxt = RD_REQ;
         end
         WR_REQ:  state_nxt = WR_WAIT;
         WR_WAIT: if (wait_end) state_nxt = WR_RESP;
         WR_RESP: if (s_axil_bready) state_nxt = IDLE;
         RD_REQ:  state_nxt = RD_WAIT;
         RD_WAIT: if (wait_end) state_nxt = RD_RESP;
         RD_RESP: if (s_axil_rready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_axil_awready = grant_wr;
      s_axil_wready  = grant_wr;
      s_axil_arready = grant_rd;
      cpu_if_write   = (state == WR_REQ);
      cpu_if_read    = (state == RD_REQ);
      s_axil_bvalid  = (state == WR_RESP);
      s_axil_rvalid  = (state == RD_RESP);
   end

   // Response fields only move on entry to a RESP state, so they are stable while valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_wr <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         bresp_q <= '0;
         rresp_q <= '0;
      end else begin
         if (grant_wr) begin
            last_wr <= 1'b1;
            addr_q  <= s_axil_awaddr[31:2];
            wdata_q <= s_axil_wdata;
            if (!strb_ok) bresp_q <= 2'b10;
         end
         if (grant_rd) begin
            last_wr <= 1'b0;
            addr_q  <= s_axil_araddr[31:2];
         end
         if (state == WR_WAIT && wait_end)
            bresp_q <= cpu_if_access_complete ? 2'b00 : 2'b10;
         if (state == RD_WAIT && wait_end) begin
            rdata_q <= cpu_if_access_complete ? cpu_if_read_data : ERR_RDATA;
            rresp_q <= cpu_if_access_complete ? 2'b00 : 2'b10;
         end
      end
   end

   assign cpu_if_address    = addr_q;
   assign cpu_if_write_data = wdata_q;
   assign s_axil_bresp      = bresp_q;
   assign s_axil_rdata      = rdata_q;
   assign s_axil_rresp      = rresp_q;

endmodule

// File: tb/tb_axil_to_cpu_if.sv
// Scoreboard bench for axil_to_cpu_if: tasks push expected cpu_if pulses and AXI responses,
// a negedge monitor pops and compares every observed event.
module tb_axil_to_cpu_if;

   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, s_axil_rdata;
   logic [3:0]  s_axil_wstrb = '0;
   logic        s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_arvalid = 0;
   logic        s_axil_bready = 1, s_axil_rready = 1;
   logic        s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid;
   logic [1:0]  s_axil_bresp, s_axil_rresp;
   logic        cpu_if_read, cpu_if_write, cpu_if_access_complete = 0;
   logic [31:0] cpu_if_write_data, cpu_if_read_data = '0;
   logic [29:0] cpu_if_address;

   int n_chk = 0, n_pass = 0, lat;
   int resp_delay = 5;
   bit resp_en = 1;
   logic [31:0] resp_data = '0;

   typedef struct {int kind; logic [31:0] a; logic [31:0] d; logic [1:0] r;} exp_t;
   localparam int K_WP = 0, K_RP = 1, K_B = 2, K_R = 3;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   axil_to_cpu_if #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
      .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
      .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .cpu_if_read(cpu_if_read), .cpu_if_write(cpu_if_write), .cpu_if_write_data(cpu_if_write_data),
      .cpu_if_address(cpu_if_address), .cpu_if_read_data(cpu_if_read_data),
      .cpu_if_access_complete(cpu_if_access_complete));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      exp_t e;
      e.kind = kind; e.a = a; e.d = d; e.r = r;
      exp_q.push_back(e);
   endtask

   task automatic sb(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_unexpected_event", kind, 32'hFFFF_FFFF);
         return;
      end
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      case (kind)
         K_WP: begin chk("wr_pulse_addr", a, e.a); chk("wr_pulse_data", d, e.d); end
         K_RP: chk("rd_pulse_addr", a, e.a);
         K_B:  chk("bresp", {30'b0, r}, {30'b0, e.r});
         default: begin chk("rresp", {30'b0, r}, {30'b0, e.r}); chk("rdata", d, e.d); end
      endcase
   endtask

   always @(negedge clk) if (!reset) begin
      if (cpu_if_write) sb(K_WP, {2'b0, cpu_if_address}, cpu_if_write_data, 2'b0);
      if (cpu_if_read)  sb(K_RP, {2'b0, cpu_if_address}, '0, 2'b0);
      if (s_axil_bvalid && s_axil_bready) sb(K_B, '0, '0, s_axil_bresp);
      if (s_axil_rvalid && s_axil_rready) sb(K_R, '0, s_axil_rdata, s_axil_rresp);
   end

   // cpu_if target model: answers each pulse resp_delay cycles later
   initial forever begin
      @(negedge clk);
      if ((cpu_if_write || cpu_if_read) && resp_en) begin
         repeat (resp_delay) @(posedge clk);
         #1 cpu_if_access_complete = 1; cpu_if_read_data = resp_data;
         @(posedge clk);
         #1 cpu_if_access_complete = 0;
      end
   end

   // lat = negedges from address handshake to first bvalid
   task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat);
      int n;
      @(posedge clk); #1;
      s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
      s_axil_awvalid = 1; s_axil_wvalid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axil_awready && n < 300);
      if (!s_axil_awready) chk("aw_handshake_timeout", 0, 1);
      @(posedge clk); #1 s_axil_awvalid = 0; s_axil_wvalid = 0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!s_axil_bvalid && lat < 300);
      if (!s_axil_bvalid) chk("bvalid_timeout", 0, 1);
      n = 0;
      while (!(s_axil_bvalid && s_axil_bready) && n < 300) begin @(negedge clk); n++; end
      @(posedge clk); #1;
   endtask

   task automatic axil_read(input logic [31:0] a, output int lat);
      int n;
      @(posedge clk); #1;
      s_axil_araddr = a; s_axil_arvalid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axil_arready && n < 300);
      if (!s_axil_arready) chk("ar_handshake_timeout", 0, 1);
      @(posedge clk); #1 s_axil_arvalid = 0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!s_axil_rvalid && lat < 300);
      if (!s_axil_rvalid) chk("rvalid_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic stray_complete();
      @(posedge clk); #1 cpu_if_access_complete = 1;
      @(posedge clk); #1 cpu_if_access_complete = 0;
   endtask

   initial begin
      int l1, l2;
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d of %0d checks done", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int l1, l2;
      repeat (3) @(negedge clk);
      chk("rst_bvalid", s_axil_bvalid, 0);
      chk("rst_rvalid", s_axil_rvalid, 0);
      chk("rst_cpu_write", cpu_if_write, 0);
      chk("rst_cpu_read", cpu_if_read, 0);
      chk("rst_address", {2'b0, cpu_if_address}, 0);
      chk("rst_rdata", s_axil_rdata, 0);
      @(posedge clk); #1 reset = 0;

      // Contended after reset: write first, then alternate
      resp_data = 32'hCAFE_0001;
      push(K_WP, 32'h40, 32'h1111_1111, 0); push(K_B, 0, 0, 2'b00);
      push(K_RP, 32'h41, 0, 0);             push(K_R, 0, 32'hCAFE_0001, 2'b00);
      push(K_WP, 32'h42, 32'h2222_2222, 0); push(K_B, 0, 0, 2'b00);
      push(K_RP, 32'h43, 0, 0);             push(K_R, 0, 32'hCAFE_0001, 2'b00);
      fork
         axil_write(32'h100, 32'h1111_1111, 4'hF, l1);
         axil_read(32'h104, l2);
      join
      fork
         axil_write(32'h108, 32'h2222_2222, 4'hF, l1);
         axil_read(32'h10C, l2);
      join

      // Basic write, complete 5 cycles after the pulse
      push(K_WP, 32'h4, 32'hA5A5_5A5A, 0); push(K_B, 0, 0, 2'b00);
      axil_write(32'h0000_0010, 32'hA5A5_5A5A, 4'hF, lat);
      chk("wr_latency", lat, 7);

      // Stray complete in IDLE, then basic read
      stray_complete();
      resp_data = 32'h1234_5678;
      push(K_RP, 32'h8, 0, 0); push(K_R, 0, 32'h1234_5678, 2'b00);
      axil_read(32'h0000_0020, lat);
      chk("rd_latency", lat, 7);
      chk("rdata_stable_idle", s_axil_rdata, 32'h1234_5678);

      // Last grant was read: contended grant goes to write; then a lone write, then contention -> read
      push(K_WP, 32'hC, 32'h3333_3333, 0); push(K_B, 0, 0, 2'b00);
      axil_write(32'h33, 32'h3333_3333, 4'hF, lat);
      resp_data = 32'h0BEE_F00D;
      push(K_RP, 32'hE, 0, 0);             push(K_R, 0, 32'h0BEE_F00D, 2'b00);
      push(K_WP, 32'hD, 32'h4444_4444, 0); push(K_B, 0, 0, 2'b00);
      fork
         axil_write(32'h34, 32'h4444_4444, 4'hF, l1);
         axil_read(32'h38, l2);
      join
      chk("addr_held_idle", {2'b0, cpu_if_address}, 32'hD);

      // Partial strobe: no cpu_if pulse, SLVERR one cycle after handshake
      push(K_B, 0, 0, 2'b10);
      axil_write(32'h40, 32'h5555_5555, 4'h3, lat);
      chk("strb_err_latency", lat, 1);

      // bready low for 10 cycles while AR is pending
      s_axil_bready = 0;
      push(K_WP, 32'h14, 32'h0BAD_F00D, 0); push(K_B, 0, 0, 2'b00);
      resp_data = 32'h7777_0000;
      push(K_RP, 32'h16, 0, 0); push(K_R, 0, 32'h7777_0000, 2'b00);
      fork
         axil_write(32'h50, 32'h0BAD_F00D, 4'hF, l1);
         begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axil_bvalid && n < 300);
            @(posedge clk); #1 s_axil_araddr = 32'h58; s_axil_arvalid = 1;
            repeat (10) begin
               @(negedge clk);
               chk("bvalid_held", s_axil_bvalid, 1);
               chk("bresp_held", {30'b0, s_axil_bresp}, 0);
               chk("no_grant_in_resp", s_axil_arready, 0);
            end
            @(posedge clk); #1 s_axil_bready = 1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axil_arready && n < 300);
            chk("ar_after_b", s_axil_arready, 1);
            @(posedge clk); #1 s_axil_arvalid = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axil_rvalid && n < 300);
            @(posedge clk); #1;
         end
      join

`ifdef CPU_IF_TIMEOUT_EN
      // No complete: abort after 16 WAIT cycles, then a late complete is ignored
      resp_en = 0;
      push(K_RP, 32'h18, 0, 0); push(K_R, 0, 32'hDEAD_BEEF, 2'b10);
      axil_read(32'h60, lat);
      chk("timeout_latency", lat, 18);
      stray_complete();
      resp_en = 1;
      resp_data = 32'h600D_600D;
      push(K_RP, 32'h19, 0, 0); push(K_R, 0, 32'h600D_600D, 2'b00);
      axil_read(32'h64, lat);
      push(K_WP, 32'h1A, 32'h9999_9999, 0); push(K_B, 0, 0, 2'b00);
      axil_write(32'h68, 32'h9999_9999, 4'hF, lat);
`endif

      repeat (5) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
